// File: rtl/keccak_padder_param_if.sv
// Word-in / block-out bus of the Keccak padder. The padder takes the slave
// modport; the message source/consumer side takes master.
interface keccak_padder_param_if #(
    parameter int W    = 64,
    parameter int RATE = 1088
);
    localparam int BNW = $clog2(W/8 + 1);

    logic [W-1:0]    in;
    logic            in_valid;
    logic            in_ready;
    logic            is_last;
    logic [BNW-1:0]  byte_num;
    logic [RATE-1:0] out;
    logic            out_valid;
    logic            out_last;
    logic            out_ack;

    modport slave (
        input  in, in_valid, is_last, byte_num, out_ack,
        output in_ready, out, out_valid, out_last
    );

    modport master (
        output in, in_valid, is_last, byte_num, out_ack,
        input  in_ready, out, out_valid, out_last
    );
endinterface

// File: rtl/keccak_padder_param.sv
// Streaming pad10*1 padder: packs W-bit words MSB-first into RATE-bit blocks
// and appends the domain byte / final 0x80, adding a padding-only block when needed.
module keccak_padder_param #(
    parameter int          W      = 64,
    parameter int          RATE   = 1088,
    parameter logic [7:0]  DSBYTE = 8'h06
) (
    input  logic clk,
    input  logic reset,
    keccak_padder_param_if.slave bus
);
    localparam int BW = W / 8;
    localparam int NW = RATE / W;
    localparam int RB = RATE / 8;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [RATE-1:0] PAD_END = RATE'(8'h80);
    localparam logic [RATE-1:0] PAD_BLK = (RATE'(DSBYTE) << (RATE - 8)) | PAD_END;

    typedef enum logic [1:0] {FILL, FULL, OVF, LAST} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RATE-1:0] buf_q, buf_d;

    int              nbytes;
    logic [W-1:0]    keep;
    logic [RATE-1:0] word_blk;
    logic [RATE-1:0] ds_blk;
    logic            slot_last;

    // Slots past cnt are always zero, so a word or the domain byte is ORed into place.
    always_comb begin
        nbytes = BW;
        if (bus.is_last && (int'(bus.byte_num) < BW))
            nbytes = int'(bus.byte_num);
        keep      = ~({W{1'b1}} >> (8 * nbytes));
        word_blk  = RATE'(bus.in & keep) << ((NW - 1 - int'(cnt_q)) * W);
        ds_blk    = RATE'(DSBYTE) << ((RB - 1 - (int'(cnt_q) * BW + nbytes)) * 8);
        slot_last = (int'(cnt_q) == NW - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    buf_d = buf_q | word_blk;
                    if (!bus.is_last) begin
                        cnt_d = slot_last ? '0 : cnt_q + CW'(1);
                        if (slot_last)
                            state_d = FULL;
                    end else if ((nbytes == BW) && slot_last) begin
                        state_d = OVF;
                    end else begin
                        // A full last word pushes the domain byte into the next slot's first byte.
                        buf_d   = buf_q | word_blk | ds_blk | PAD_END;
                        state_d = LAST;
                    end
                end
            end
            FULL, LAST: begin
                if (bus.out_ack) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            OVF: begin
                if (bus.out_ack) begin
                    buf_d   = PAD_BLK;
                    state_d = LAST;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q != FILL);
    assign bus.out_last  = (state_q == LAST);
    assign bus.out       = buf_q;
endmodule

// File: tb/tb_keccak_padder_param.sv
// Bench for keccak_padder_param: SHA3-256, SHA3-512 and SHAKE128 instances
// checked against a byte-level pad10*1 model with directed tables and random messages.
module tb_keccak_padder_param;
    localparam int MAXR = 1344;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [63:0]     in_w [3];
    logic            iv   [3];
    logic            il   [3];
    logic [3:0]      bn   [3];
    logic            ack  [3];
    logic            rdy  [3];
    logic            ov   [3];
    logic            ol   [3];
    logic [MAXR-1:0] ob   [3];

    int nvec = 0;
    int nmis = 0;

    keccak_padder_param_if #(.W(64), .RATE(1088)) if0 ();
    keccak_padder_param_if #(.W(64), .RATE(576))  if1 ();
    keccak_padder_param_if #(.W(64), .RATE(1344)) if2 ();

    keccak_padder_param #(.W(64), .RATE(1088), .DSBYTE(8'h06)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    keccak_padder_param #(.W(64), .RATE(576),  .DSBYTE(8'h06)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    keccak_padder_param #(.W(64), .RATE(1344), .DSBYTE(8'h1F)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.in = in_w[0]; assign if0.in_valid = iv[0]; assign if0.is_last = il[0];
    assign if0.byte_num = bn[0]; assign if0.out_ack = ack[0];
    assign if1.in = in_w[1]; assign if1.in_valid = iv[1]; assign if1.is_last = il[1];
    assign if1.byte_num = bn[1]; assign if1.out_ack = ack[1];
    assign if2.in = in_w[2]; assign if2.in_valid = iv[2]; assign if2.is_last = il[2];
    assign if2.byte_num = bn[2]; assign if2.out_ack = ack[2];

    assign rdy[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign ol[0] = if0.out_last;
    assign ob[0]  = MAXR'(if0.out);
    assign rdy[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign ol[1] = if1.out_last;
    assign ob[1]  = MAXR'(if1.out);
    assign rdy[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign ol[2] = if2.out_last;
    assign ob[2]  = MAXR'(if2.out);

    typedef struct {
        int         d;
        int         len;
        int         hold;
        bit         trail;
        int         exp_blocks;
        logic [7:0] exp_final;
    } vec_t;

    vec_t tab [14];

    function automatic int rb_of(input int d);
        return (d == 0) ? 136 : ((d == 1) ? 72 : 168);
    endfunction

    function automatic logic [7:0] ds_of(input int d);
        return (d == 2) ? 8'h1F : 8'h06;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBlock(input string name, input logic [MAXR-1:0] act,
                              input logic [MAXR-1:0] exp, input int rb);
        int k;
        nvec++;
        if (act !== exp) begin
            nmis++;
            k = -1;
            for (int i = 0; i < rb; i++)
                if (k < 0 && act[(rb-1-i)*8 +: 8] !== exp[(rb-1-i)*8 +: 8]) k = i;
            if (k >= 0)
                $display("[TB] FAIL %s: byte %0d got %02h, expected %02h", name, k,
                         act[(rb-1-k)*8 +: 8], exp[(rb-1-k)*8 +: 8]);
            else
                $display("[TB] FAIL %s: block differs outside rate bytes", name);
        end
    endtask

    task automatic idle(input int d);
        iv[d] = 1'b0; il[d] = 1'b0; bn[d] = 4'd0; ack[d] = 1'b0; in_w[d] = '0;
    endtask

    // Sends a len-byte random message and drains every block, holding each block
    // for 'hold' cycles with junk words offered; blocks come from the byte model.
    task automatic applyStimulus(input int d, input int len, input int hold, input bit trail,
                                 input bit wide_bn, output int nblk, output logic [7:0] fin);
        int rb, nw, ntot, nfull, rem, wi, bi, wib, hcnt, cyc;
        byte unsigned msg[$];
        byte unsigned pb[$];
        logic [63:0] wd[$];
        bit          wl[$];
        logic [3:0]  wb[$];
        logic [63:0] w;
        logic [MAXR-1:0] expb;
        bit expect_ov, expect_rdy, seen;

        rb = rb_of(d); nw = rb / 8;
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        ntot = len / rb + 1;
        pb = msg;
        while (pb.size() < ntot * rb) pb.push_back(8'h00);
        pb[len] = ds_of(d);
        pb[ntot*rb-1] = pb[ntot*rb-1] | 8'h80;

        nfull = len / 8; rem = len % 8;
        for (int k = 0; k < nfull; k++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w[63-8*j -: 8] = msg[8*k+j];
            wd.push_back(w); wl.push_back(1'b0); wb.push_back(4'($urandom));
        end
        if (rem != 0 || len == 0 || trail) begin
            w = {$urandom, $urandom};
            for (int j = 0; j < rem; j++) w[63-8*j -: 8] = msg[8*nfull+j];
            wd.push_back(w); wl.push_back(1'b1); wb.push_back(4'(rem));
        end else begin
            wl[nfull-1] = 1'b1;
            wb[nfull-1] = wide_bn ? 4'($urandom_range(15, 8)) : 4'd8;
        end

        wi = 0; bi = 0; wib = 0; hcnt = 0; cyc = 0; nblk = 0; fin = 8'h00;
        expect_ov = 0; expect_rdy = 0; seen = 0;
        while ((wi < wd.size() || bi < ntot) && cyc < 2000) begin
            if (expect_ov) checkOutput("latency_out_valid", 32'(ov[d]), 32'd1);
            if (expect_rdy) checkOutput("ready_after_ack", 32'(rdy[d]), 32'd1);
            expect_ov = 0; expect_rdy = 0;
            if (ov[d]) begin
                if (bi >= ntot) begin
                    checkOutput("extra_block", 32'(bi), 32'(ntot - 1));
                    idle(d); ack[d] = 1'b1; bi++;
                end else begin
                    expb = '0;
                    for (int k = 0; k < rb; k++) expb = {expb[MAXR-9:0], pb[bi*rb+k]};
                    if (!seen) begin
                        checkBlock("block_data", ob[d], expb, rb);
                        checkOutput("block_last", 32'(ol[d]), 32'(bi == ntot - 1));
                        seen = 1;
                    end else begin
                        checkBlock("hold_stable", ob[d], expb, rb);
                        checkOutput("hold_ready_low", 32'(rdy[d]), 32'd0);
                    end
                    if (hcnt < hold) begin
                        ack[d] = 1'b0; iv[d] = 1'b1; il[d] = 1'($urandom);
                        bn[d] = 4'($urandom); in_w[d] = {$urandom, $urandom};
                        hcnt++;
                    end else begin
                        idle(d); ack[d] = 1'b1;
                        fin = ob[d][7:0]; nblk++;
                        bi++; hcnt = 0; seen = 0;
                        if (wi >= wd.size() && bi < ntot) expect_ov = 1;
                        else expect_rdy = 1;
                    end
                end
            end else if (rdy[d] && wi < wd.size()) begin
                ack[d] = 1'b0; iv[d] = 1'b1; in_w[d] = wd[wi];
                il[d] = wl[wi]; bn[d] = wb[wi];
                wib++;
                if (wib == nw || wl[wi]) begin
                    expect_ov = 1; wib = 0;
                end
                wi++;
            end else begin
                idle(d);
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle(d);
        if (cyc >= 2000) checkOutput("timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        int nblk;
        logic [7:0] fin;
        logic [1087:0] empty_blk;

        tab[0]  = '{0,   0, 0, 1'b0, 1, 8'h80};
        tab[1]  = '{0,  32, 1, 1'b0, 1, 8'h80};
        tab[2]  = '{0, 135, 0, 1'b0, 1, 8'h86};
        tab[3]  = '{0, 136, 3, 1'b0, 2, 8'h80};
        tab[4]  = '{0, 136, 5, 1'b0, 2, 8'h80};
        tab[5]  = '{0, 128, 0, 1'b0, 1, 8'h80};
        tab[6]  = '{0, 136, 0, 1'b1, 2, 8'h80};
        tab[7]  = '{0, 271, 1, 1'b0, 2, 8'h86};
        tab[8]  = '{1,  71, 0, 1'b0, 1, 8'h86};
        tab[9]  = '{1,  72, 2, 1'b0, 2, 8'h80};
        tab[10] = '{1,  64, 0, 1'b0, 1, 8'h80};
        tab[11] = '{2, 167, 0, 1'b0, 1, 8'h9F};
        tab[12] = '{2, 168, 1, 1'b0, 2, 8'h80};
        tab[13] = '{2, 160, 0, 1'b0, 1, 8'h80};

        for (int d = 0; d < 3; d++) idle(d);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset_in_ready", 32'(rdy[d]), 32'd1);
            checkOutput("reset_out_valid", 32'(ov[d]), 32'd0);
            checkOutput("reset_out_last", 32'(ol[d]), 32'd0);
            checkBlock("reset_out", ob[d], '0, rb_of(d));
        end

        // Empty message: padded block appears the cycle after the single handshake.
        @(posedge clk); #1;
        iv[0] = 1'b1; il[0] = 1'b1; bn[0] = 4'd0; in_w[0] = 64'hDEAD_BEEF_0123_4567;
        @(posedge clk); #1;
        idle(0);
        empty_blk = {8'h06, 1072'h0, 8'h80};
        checkOutput("empty_valid", 32'(ov[0]), 32'd1);
        checkOutput("empty_last", 32'(ol[0]), 32'd1);
        checkOutput("empty_ready", 32'(rdy[0]), 32'd0);
        checkBlock("empty_block", ob[0], MAXR'(empty_blk), 136);
        ack[0] = 1'b1;
        @(posedge clk); #1;
        ack[0] = 1'b0;
        checkOutput("empty_ack_ready", 32'(rdy[0]), 32'd1);
        checkOutput("empty_ack_valid", 32'(ov[0]), 32'd0);

        for (int t = 0; t < 14; t++) begin
            applyStimulus(tab[t].d, tab[t].len, tab[t].hold, tab[t].trail,
                          1'($urandom), nblk, fin);
            checkOutput("table_blocks", 32'(nblk), 32'(tab[t].exp_blocks));
            checkOutput("table_final_byte", 32'(fin), 32'(tab[t].exp_final));
        end

        // Reset in the middle of a block discards the partial data at once.
        for (int k = 0; k < 5; k++) begin
            iv[0] = 1'b1; il[0] = 1'b0; in_w[0] = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        idle(0);
        reset = 1'b1;
        #1;
        checkOutput("midreset_valid", 32'(ov[0]), 32'd0);
        checkOutput("midreset_ready", 32'(rdy[0]), 32'd1);
        checkBlock("midreset_out", ob[0], '0, 136);
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1'b0, 1'b0, nblk, fin);
        checkOutput("midreset_empty_blocks", 32'(nblk), 32'd1);

        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 20; r++)
                applyStimulus(d, $urandom_range(0, 3 * rb_of(d)), $urandom_range(0, 2),
                              1'($urandom), 1'($urandom), nblk, fin);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
